// File: rtl/vec_mul_host.sv
// Initiator end of the UART vector-multiply link: sends vec1 then vec2 as WIDTH-bit
// frames, collects N 2*WIDTH-bit results. Optional response timeout: VEC_HOST_TIMEOUT_EN.
module vec_mul_host #(
   parameter int N              = 8,
   parameter int WIDTH          = 8,
   parameter int CLKS_PER_BIT   = 16,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [N*WIDTH-1:0]       vec1,
   input  logic [N*WIDTH-1:0]       vec2,
   input  logic                     rx,
   output logic                     tx,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [2*N*WIDTH-1:0]     result
);

   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(RW + 2);
   localparam int EW = $clog2(2 * N);

   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] TX_STOP = BW'(WIDTH + 1);
   localparam logic [BW-1:0] RX_STOP = BW'(RW + 1);
   localparam logic [BW-1:0] TX_DBITS = BW'(WIDTH);
   localparam logic [EW-1:0] TX_LAST = EW'(2 * N - 1);
   localparam logic [EW-1:0] RX_LAST = EW'(N - 1);

   typedef enum logic [1:0] {IDLE, SEND, RECV} state_t;

   state_t                  state_q, state_d;
   logic                    tx_q, tx_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [2*N*WIDTH-1:0]    ops_q, ops_d;
   logic [2*N*WIDTH-1:0]    result_q, result_d;
   logic [CW-1:0]           clk_cnt_q, clk_cnt_d;
   logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
   logic [EW-1:0]           elem_q, elem_d;
   logic                    rx_act_q, rx_act_d;
   logic [RW-1:0]           rdata_q, rdata_d;
   logic                    rx_s1_q, rx_s2_q, rx_prev_q;
   logic [WIDTH-1:0]        cur_elem, tx_shift;

`ifdef VEC_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          to_clr;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      done_d    = 1'b0;
      err_d     = err_q;
      ops_d     = ops_q;
      result_d  = result_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      elem_d    = elem_q;
      rx_act_d  = rx_act_q;
      rdata_d   = rdata_q;
      cur_elem  = ops_q[elem_q*WIDTH +: WIDTH];
      tx_shift  = cur_elem >> bit_cnt_q;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (start) begin
               state_d   = SEND;
               ops_d     = {vec2, vec1};
               err_d     = 1'b0;
               elem_d    = '0;
               clk_cnt_d = '0;
               bit_cnt_d = '0;
               rx_act_d  = 1'b0;
               tx_d      = 1'b0;
            end
         end
         SEND: begin
            if (clk_cnt_q == FULL_M1) begin
               clk_cnt_d = '0;
               if (bit_cnt_q == TX_STOP) begin
                  bit_cnt_d = '0;
                  if (elem_q == TX_LAST) begin
                     state_d = RECV;
                     elem_d  = '0;
                     tx_d    = 1'b1;
                  end else begin
                     elem_d = elem_q + 1'b1;
                     tx_d   = 1'b0;
                  end
               end else begin
                  // moving from frame bit b to b+1 puts data bit b on the line
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  tx_d      = (bit_cnt_q < TX_DBITS) ? tx_shift[0] : 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         RECV: begin
            tx_d = 1'b1;
            if (!rx_act_q) begin
               if (rx_prev_q && !rx_s2_q) begin
                  rx_act_d  = 1'b1;
                  clk_cnt_d = '0;
                  bit_cnt_d = '0;
               end
            end else if (bit_cnt_q == '0) begin
               if (clk_cnt_q == HALF_M1) begin
                  clk_cnt_d = '0;
                  if (rx_s2_q) rx_act_d = 1'b0;
                  else         bit_cnt_d = 1;
               end else begin
                  clk_cnt_d = clk_cnt_q + 1'b1;
               end
            end else if (clk_cnt_q == FULL_M1) begin
               clk_cnt_d = '0;
               if (bit_cnt_q == RX_STOP) begin
                  rx_act_d = 1'b0;
                  if (rx_s2_q) begin
                     result_d[elem_q*RW +: RW] = rdata_q;
                     if (elem_q == RX_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        elem_d  = '0;
                     end else begin
                        elem_d = elem_q + 1'b1;
                     end
                  end else begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  rdata_d   = {rx_s2_q, rdata_q[RW-1:1]};
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef VEC_HOST_TIMEOUT_EN
      // restarted on RECV entry and on every start bit confirmed at mid-bit
      to_clr   = rx_act_q && (bit_cnt_q == '0) && (clk_cnt_q == HALF_M1) && !rx_s2_q;
      to_cnt_d = '0;
      if (state_q == RECV) begin
         to_cnt_d = to_clr ? '0 : to_cnt_q + 1'b1;
         if (state_d == RECV && to_cnt_q == TO_LAST) begin
            state_d  = IDLE;
            err_d    = 1'b1;
            rx_act_d = 1'b0;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         ops_q     <= '0;
         result_q  <= '0;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         elem_q    <= '0;
         rx_act_q  <= 1'b0;
         rdata_q   <= '0;
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
`ifdef VEC_HOST_TIMEOUT_EN
         to_cnt_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
         err_q     <= err_d;
         ops_q     <= ops_d;
         result_q  <= result_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         elem_q    <= elem_d;
         rx_act_q  <= rx_act_d;
         rdata_q   <= rdata_d;
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
`ifdef VEC_HOST_TIMEOUT_EN
         to_cnt_q  <= to_cnt_d;
`endif
      end
   end

   assign tx     = tx_q;
   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;

endmodule

// File: tb/tb_vec_mul_host.sv
// Directed bench for vec_mul_host (N=2, WIDTH=8, CLKS_PER_BIT=4): decodes tx frames,
// replies on rx with hand-chosen results and checks result/done/err/busy timing.
module tb_vec_mul_host;
   localparam int N = 2, W = 8, CPB = 4, TO = 200;

   logic            clk = 1'b0, rst = 1'b0, start = 1'b0, rx = 1'b1;
   logic [N*W-1:0]  vec1 = '0, vec2 = '0;
   logic            tx, busy, done, err;
   logic [2*N*W-1:0] result;

   int errs = 0, checks = 0;
   int cyc = 0, done_cnt = 0, ts = 0;

   vec_mul_host #(.N(N), .WIDTH(W), .CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .vec1(vec1), .vec2(vec2), .rx(rx),
      .tx(tx), .busy(busy), .done(done), .err(err), .result(result));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // start pulse at a negedge; one cycle later busy/tx must already reflect SEND
   task automatic do_start(input logic [15:0] v1, input logic [15:0] v2);
      vec1 = v1; vec2 = v2; start = 1'b1; ts = cyc;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("tx_start_bit_1cyc", tx, 0);
      chk("err_cleared", err, 0);
   endtask

   task automatic get_tx(output logic [7:0] b, output int t0);
      int n = 0;
      b = '0;
      while (tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
      t0 = cyc;
      if (n >= 200) chk("tx_frame_timeout", 0, 1);
      else begin
         repeat (2) @(negedge clk);
         chk("tx_start_mid", tx, 0);
         for (int j = 0; j < W; j++) begin
            repeat (CPB) @(negedge clk);
            b[j] = tx;
         end
         repeat (CPB) @(negedge clk);
         chk("tx_stop", tx, 1);
      end
   endtask

   // decode all 2N frames; optionally pulse start (with new operands) after frame 0
   task automatic chk_frames(input logic [31:0] exp, input logic poke);
      logic [7:0] b;
      int t0;
      for (int k = 0; k < 2*N; k++) begin
         get_tx(b, t0);
         chk("tx_byte", b, exp[8*k +: 8]);
         chk("tx_frame_offset", t0 - ts, 1 + 40*k);
         if (poke && k == 0) begin
            start = 1'b1; vec1 = 16'hFFFF; vec2 = 16'hFFFF;
            @(negedge clk);
            start = 1'b0;
            chk("busy_mid_send", busy, 1);
         end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic send_rx(input logic [15:0] d, input logic stop);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int j = 0; j < 2*W; j++) begin
         rx = d[j];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int dc;
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_result", result, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // transaction A: second reply has a bad stop bit
      dc = done_cnt;
      do_start(16'h2211, 16'h4433);
      chk_frames(32'h44332211, 1'b0);
      send_rx(16'h0008, 1'b1);
      send_rx(16'h000F, 1'b0);
      repeat (3) @(negedge clk);
      chk("stoperr_err", err, 1);
      chk("stoperr_busy", busy, 0);
      chk("stoperr_no_done", done_cnt - dc, 0);
      chk("stoperr_result", result, 32'h0000_0008);

      // transaction B: normal, err from A cleared by start
      dc = done_cnt;
      do_start(16'h0302, 16'h0504);
      chk_frames(32'h05040302, 1'b0);
      chk("send_over_tx_idle", tx, 1);
      send_rx(16'h0008, 1'b1);
      send_rx(16'h000F, 1'b1);
      wait_done();
      chk("norm_result", result, 32'h000F_0008);
      chk("norm_err", err, 0);
      chk("norm_busy_in_done", busy, 0);

      // transaction C started in the done cycle; start poked mid-SEND; rx glitch
      do_start(16'hA1A0, 16'hB1B0);
      chk("norm_one_done", done_cnt - dc, 1);
      chk_frames(32'hB1B0A1A0, 1'b1);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      chk("glitch_busy", busy, 1);
      chk("glitch_result_kept", result, 32'h000F_0008);
      send_rx(16'h1234, 1'b1);
      send_rx(16'hBEEF, 1'b1);
      wait_done();
      chk("glitch_result", result, 32'hBEEF_1234);
      chk("glitch_err", err, 0);
      @(negedge clk);
      chk("done_pulse_1cyc", done, 0);
      chk("idle_tx", tx, 1);

      // transaction D: no reply
      do_start(16'h0101, 16'h0202);
      repeat (359) @(negedge clk);
      chk("to_busy_pre", busy, 1);
      @(negedge clk);
`ifdef VEC_HOST_TIMEOUT_EN
      chk("to_busy", busy, 0);
      chk("to_err", err, 1);
`else
      repeat (1000) @(negedge clk);
      chk("no_to_busy", busy, 1);
      chk("no_to_err", err, 0);
`endif
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst2_busy", busy, 0);
      chk("rst2_result", result, 0);

      // reset in the middle of frame 1's start bit
      do_start(16'h0000, 16'h0000);
      repeat (40) @(negedge clk);
      chk("midsend_tx_low", tx, 0);
      rst = 1'b0;
      #1;
      chk("midsend_rst_tx", tx, 1);
      chk("midsend_rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_tx", tx, 1);
      chk("post_rst_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/vec_mul_host.md
# vec_mul_host

Host-side counterpart of the UART vector-multiply engine. On a start pulse it serialises two N-element operand vectors over `tx` as WIDTH-bit UART frames, then receives N result frames of 2*WIDTH bits on `rx` and assembles them into a parallel result bus. It is the initiator end of the vector link, used as the on-chip driver in system builds and as the bench-side peer.

## Interface

- N, 8, elements per vector
- WIDTH, 8, operand element width in bits; result elements are 2*WIDTH
- CLKS_PER_BIT, 16, clock cycles per UART bit, minimum 4
- TIMEOUT_CYCLES, 100000, response timeout in cycles (used only with VEC_HOST_TIMEOUT_EN)

- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a transaction; sampled only in IDLE
- vec1  in  N*WIDTH  operand A; element i = [(i+1)*WIDTH-1 : i*WIDTH]
- vec2  in  N*WIDTH  operand B, same packing
- rx  in  1  serial input from the engine; asynchronous
- tx  out  1  serial output to the engine; idles high
- busy  out  1  high from the cycle after accepted start until return to IDLE
- done  out  1  one-cycle pulse when all N results are captured
- err  out  1  framing error or timeout on the last transaction; cleared by the next accepted start
- result  out  2*N*WIDTH  element i = [(i+1)*2*WIDTH-1 : i*2*WIDTH]

## Operation

- Frame format, both directions: 1 start bit (0), data LSB first, 1 stop bit (1). tx frames carry WIDTH data bits; rx frames carry 2*WIDTH.
- Operands are latched when start is accepted; later vec1/vec2 changes do not affect the transaction.
- FSM states: IDLE -> SEND -> RECV -> IDLE.
- IDLE: tx=1, busy=0. When start=1, latch the operands, clear err and the element counter, and go to SEND.
- SEND: transmit 2*N frames back-to-back in this order: vec1[0..N-1], then vec2[0..N-1]. No gap beyond the stop bit. After the last stop bit, clear the counter and go to RECV.
- RECV:
  - rx passes through a 2-flop synchroniser.
  - A falling edge starts a bit timer. The start bit is re-sampled at CLKS_PER_BIT/2. If it reads 1, the edge is a false start: ignore it and re-arm.
  - Data bits are sampled at each following bit centre; the stop bit is sampled at its centre.
  - Stop bit = 1: write the frame to the result element at the counter index, then increment the counter. After the N-th element, pulse done and go to IDLE.
  - Stop bit = 0: set err, go to IDLE, no done pulse. Elements already written stay as written.
- result holds its value until overwritten by a later transaction.
- start is ignored while busy=1.
- rx activity in IDLE or SEND is ignored.

## Timing

- Reset values: tx=1, busy=0, done=0, err=0, result=0, FSM=IDLE, counters=0. Reset mid-transaction aborts immediately; tx returns high asynchronously.
- start accepted on edge k: busy=1 and the first start bit on tx from edge k+1.
- Each tx frame lasts exactly (WIDTH+2)*CLKS_PER_BIT cycles. The SEND phase lasts 2*N*(WIDTH+2)*CLKS_PER_BIT cycles.
- Result element i is written on the edge that samples its stop-bit centre. Sync latency is 2 cycles after the line transition.
- done pulses on the edge after the last stop-bit sample. busy falls on the same edge.
- A start asserted in the done cycle is accepted: the FSM is in IDLE that cycle.

## Configuration

- VEC_HOST_TIMEOUT_EN defined:
  - In RECV, a cycle counter is cleared at RECV entry and at every accepted start bit.
  - When it reaches TIMEOUT_CYCLES: err=1, return to IDLE, no done.
- VEC_HOST_TIMEOUT_EN undefined: no counter is built. RECV waits indefinitely; only reset exits it.

## Test plan

Use N=2, WIDTH=8, CLKS_PER_BIT=4.

- Normal transaction: vec1={0x03,0x02} (element0=0x02), vec2={0x05,0x04}; the bench decodes tx and replies 0x0008, 0x000F -> tx bytes are 0x02, 0x03, 0x04, 0x05; result=0x000F0008; one done pulse; err=0.
- Framing: tx start bit begins 1 cycle after start; each frame is 40 cycles; 160 cycles total in SEND; tx=1 between transactions.
- Stop-bit error: the second reply frame has stop=0 -> err=1, busy=0, no done, result[15:0]=0x0008.
- Robustness: a 1-cycle low glitch on rx in RECV is rejected, and the following valid frames are captured correctly. start pulsed mid-SEND is ignored. rst low mid-SEND drives tx=1 and busy=0 immediately.
- Timeout, macro defined with TIMEOUT_CYCLES=200: no reply -> err=1 and IDLE 200 cycles after RECV entry. Macro undefined: busy stays 1 after 1000 cycles.
- Back-to-back: start is asserted in the done cycle -> a new transaction starts on the next edge, and err from the prior transaction is cleared.
